// File: rtl/histogram_cdf_read.sv
// histogram_cdf_read: two-pass CLAHE reader (clip, redistribute, CDF map) on histogram RAM port B.
// Optional feature macro CLAHE_RESIDUAL_EN spreads the excess remainder over the lowest bins.
module histogram_cdf_read #(
  parameter logic [15:0] CLIP_LIMIT  = 16'd64,
  parameter int          PIXEL_SHIFT = 12,
  parameter int          RD_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        area_flag,
  input  logic [3:0]  tile_sel,
  output logic [7:0]  portb_addr,
  output logic [31:0] portb_rden_bus,
  input  logic [15:0] portb_rd_data,
  output logic        map_valid,
  output logic [7:0]  map_addr,
  output logic [7:0]  map_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_P1, S_P1_DRAIN, S_P2, S_P2_DRAIN, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [4:0]  sel_q, sel_d;
  logic [23:0] excess_q, excess_d;
  logic [23:0] cdf_q, cdf_d;
  logic        mv_q, mv_d;
  logic [7:0]  ma_q, ma_d;
  logic [7:0]  md_q, md_d;

  logic [RD_LATENCY-1:0] pv_q, pp_q;
  logic [7:0]            pk_q [RD_LATENCY];

  logic        active, issue;
  logic        rv, rp;
  logic [7:0]  rk;
  logic [15:0] over, clipped, redist;
  logic [24:0] exc_sum, c, cdf_sum;
  logic [23:0] cdf_new;
  logic [31:0] prod, scaled;
  logic [7:0]  map_val;
  logic        bonus;
`ifdef CLAHE_RESIDUAL_EN
  logic [7:0]  residual;
`endif

  assign active = (state_q == S_P1) || (state_q == S_P1_DRAIN) ||
                  (state_q == S_P2) || (state_q == S_P2_DRAIN);
  assign issue  = (state_q == S_P1) || (state_q == S_P2);

  assign rv = pv_q[RD_LATENCY-1];
  assign rp = pp_q[RD_LATENCY-1];
  assign rk = pk_q[RD_LATENCY-1];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      S_IDLE: begin
        addr_d = 8'd0;
        if (start) begin
          state_d = S_P1;
          sel_d   = {area_flag, tile_sel};
        end
      end
      S_P1: begin
        addr_d = addr_q + 8'd1;
        if (addr_q == 8'hFF) begin
          state_d = S_P1_DRAIN;
          addr_d  = addr_q;
          cnt_d   = 2'd0;
        end
      end
      S_P1_DRAIN: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(RD_LATENCY - 1)) begin
          state_d = S_P2;
          addr_d  = 8'd0;
          cnt_d   = 2'd0;
        end
      end
      S_P2: begin
        addr_d = addr_q + 8'd1;
        if (addr_q == 8'hFF) begin
          state_d = S_P2_DRAIN;
          addr_d  = addr_q;
          cnt_d   = 2'd0;
        end
      end
      S_P2_DRAIN: begin
        // One extra cycle lets the registered map output retire before done.
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(RD_LATENCY)) begin
          state_d = S_DONE;
          addr_d  = 8'd0;
          cnt_d   = 2'd0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    over    = 16'd0;
    clipped = portb_rd_data;
    if (portb_rd_data > CLIP_LIMIT) begin
      over    = portb_rd_data - CLIP_LIMIT;
      clipped = CLIP_LIMIT;
    end
    exc_sum = {1'b0, excess_q} + 25'(over);
    redist  = excess_q[23:8];
    bonus   = 1'b0;
`ifdef CLAHE_RESIDUAL_EN
    residual = excess_q[7:0];
    bonus    = (rk < residual);
`endif
    c       = 25'(clipped) + 25'(redist) + 25'(bonus);
    cdf_sum = {1'b0, cdf_q} + c;
    cdf_new = cdf_sum[24] ? 24'hFFFFFF : cdf_sum[23:0];
    prod    = 32'(cdf_new) * 32'd255;
    scaled  = prod >> PIXEL_SHIFT;
    map_val = (scaled > 32'd255) ? 8'hFF : scaled[7:0];

    excess_d = excess_q;
    cdf_d    = cdf_q;
    if ((state_q == S_IDLE) && start) begin
      excess_d = 24'd0;
      cdf_d    = 24'd0;
    end
    if (rv && !rp) begin
      excess_d = exc_sum[24] ? 24'hFFFFFF : exc_sum[23:0];
    end
    if (rv && rp) begin
      cdf_d = cdf_new;
    end

    mv_d = rv && rp;
    ma_d = (rv && rp) ? rk : 8'd0;
    md_d = (rv && rp) ? map_val : 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= 8'd0;
      cnt_q    <= 2'd0;
      sel_q    <= 5'd0;
      excess_q <= 24'd0;
      cdf_q    <= 24'd0;
      mv_q     <= 1'b0;
      ma_q     <= 8'd0;
      md_q     <= 8'd0;
      pv_q     <= '0;
      pp_q     <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pk_q[i] <= 8'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      excess_q <= excess_d;
      cdf_q    <= cdf_d;
      mv_q     <= mv_d;
      ma_q     <= ma_d;
      md_q     <= md_d;
      pv_q[0]  <= issue;
      pp_q[0]  <= (state_q == S_P2);
      pk_q[0]  <= addr_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pp_q[i] <= pp_q[i-1];
        pk_q[i] <= pk_q[i-1];
      end
    end
  end

  assign portb_addr     = addr_q;
  assign portb_rden_bus = active ? (32'd1 << sel_q) : 32'd0;
  assign map_valid      = mv_q;
  assign map_addr       = ma_q;
  assign map_data       = md_q;
  assign busy           = active;
  assign done           = (state_q == S_DONE);

endmodule

// File: tb/tb_histogram_cdf_read.sv
// tb_histogram_cdf_read: directed bench for histogram_cdf_read.
// Three instances (RD_LATENCY 1,2,3) share stimulus; index 1 is the default build.
module tb_histogram_cdf_read;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       area_flag = 1'b0;
  logic [3:0] tile_sel = 4'd0;

  always #5 clk = ~clk;

  logic [7:0]  pa [3];
  logic [31:0] rb [3];
  logic [15:0] rd [3];
  logic [2:0]  mv, bz, dn;
  logic [7:0]  ma [3];
  logic [7:0]  md [3];

  histogram_cdf_read #(.RD_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start), .area_flag(area_flag),
    .tile_sel(tile_sel), .portb_addr(pa[0]), .portb_rden_bus(rb[0]),
    .portb_rd_data(rd[0]), .map_valid(mv[0]), .map_addr(ma[0]),
    .map_data(md[0]), .busy(bz[0]), .done(dn[0])
  );

  histogram_cdf_read u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .area_flag(area_flag),
    .tile_sel(tile_sel), .portb_addr(pa[1]), .portb_rden_bus(rb[1]),
    .portb_rd_data(rd[1]), .map_valid(mv[1]), .map_addr(ma[1]),
    .map_data(md[1]), .busy(bz[1]), .done(dn[1])
  );

  histogram_cdf_read #(.RD_LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .start(start), .area_flag(area_flag),
    .tile_sel(tile_sel), .portb_addr(pa[2]), .portb_rden_bus(rb[2]),
    .portb_rd_data(rd[2]), .map_valid(mv[2]), .map_addr(ma[2]),
    .map_data(md[2]), .busy(bz[2]), .done(dn[2])
  );

  // RAM model: data only returns when the expected tile RAM is enabled
  logic [15:0] mem [256];
  logic [15:0] rpipe [3][3];
  logic [31:0] exp_rden = 32'd0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      rpipe[i][0] <= (rb[i] == exp_rden) ? mem[pa[i]] : 16'd0;
      rpipe[i][1] <= rpipe[i][0];
      rpipe[i][2] <= rpipe[i][1];
    end
  end

  assign rd[0] = rpipe[0][0];
  assign rd[1] = rpipe[1][1];
  assign rd[2] = rpipe[2][2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         vcnt [3];
  int         seqn [3];
  int         seqerr [3];
  int         dcnt [3];
  int         dcyc [3];
  int         lastv [3];
  int         selerr;
  int         scyc;
  logic [7:0] cap [3][256];
  logic [7:0] exp_map [256];

  int checks = 0;
  int failures = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mv[i]) begin
        cap[i][ma[i]] = md[i];
        if (ma[i] != seqn[i][7:0]) seqerr[i]++;
        seqn[i]++;
        vcnt[i]++;
        lastv[i] = cyc;
      end
      if (dn[i]) begin
        dcnt[i]++;
        dcyc[i] = cyc;
      end
    end
    if (bz[1] ? (rb[1] !== exp_rden) : (rb[1] !== 32'd0)) selerr++;
  end

  task automatic clear_caps();
    for (int i = 0; i < 3; i++) begin
      vcnt[i] = 0; seqn[i] = 0; seqerr[i] = 0;
      dcnt[i] = 0; dcyc[i] = 0; lastv[i] = 0;
      for (int k = 0; k < 256; k++) cap[i][k] = 8'h5A;
    end
    selerr = 0;
  endtask

  // Independent reference: clip, redistribute, CDF, scale by 255/4096
  task automatic model();
    int exc, redist, res, cdf, h, cc;
    longint m;
    exc = 0;
    for (int b = 0; b < 256; b++)
      if (mem[b] > 16'd64) exc += int'(mem[b]) - 64;
    redist = exc / 256;
    res = exc % 256;
    cdf = 0;
    for (int k = 0; k < 256; k++) begin
      h = int'(mem[k]);
      cc = ((h > 64) ? 64 : h) + redist;
`ifdef CLAHE_RESIDUAL_EN
      if (k < res) cc++;
`endif
      cdf += cc;
      m = (longint'(cdf) * 255) / 4096;
      exp_map[k] = (m > 255) ? 8'hFF : 8'(m);
    end
  endtask

  task automatic pulse_start(input logic a, input logic [3:0] t);
    clear_caps();
    exp_rden = 32'd1 << {a, t};
    area_flag = a;
    tile_sel = t;
    start = 1'b1;
    scyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      ok = (dcnt[0] > 0) && (dcnt[1] > 0) && (dcnt[2] > 0);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] o;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      o = {pa[i], rb[i], mv[i], ma[i], md[i], bz[i], dn[i]};
      checks++;
      if (o !== 64'd0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d got=%h required=0", i, o);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_uniform();
    bit ok;
    int bad;
    for (int b = 0; b < 256; b++) mem[b] = 16'd16;
    model();
    pulse_start(1'b0, 4'd0);
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL uniform_done_timeout got=0 required=1"); end
    checks++;
    if (vcnt[1] != 256) begin
      failures++; $display("FAIL uniform_valid_count got=%0d required=256", vcnt[1]);
    end
    checks++;
    if (cap[1][0] !== 8'd0) begin
      failures++; $display("FAIL uniform_map0 got=%0d required=0", cap[1][0]);
    end
    checks++;
    if (cap[1][127] !== 8'd127) begin
      failures++; $display("FAIL uniform_map127 got=%0d required=127", cap[1][127]);
    end
    checks++;
    if (cap[1][255] !== 8'd255) begin
      failures++; $display("FAIL uniform_map255 got=%0d required=255", cap[1][255]);
    end
    checks++;
    if (dcyc[1] != lastv[1] + 1) begin
      failures++;
      $display("FAIL uniform_done_after_last got=%0d required=%0d", dcyc[1], lastv[1] + 1);
    end
    checks++;
    if (seqerr[1] != 0) begin
      failures++; $display("FAIL uniform_addr_seq got=%0d required=0", seqerr[1]);
    end
    bad = 0;
    for (int k = 0; k < 256; k++) if (cap[1][k] !== exp_map[k]) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL uniform_map_model got=%0d required=0", bad);
    end
  endtask

  task automatic test_spike();
    bit ok;
    int bad;
    logic [7:0] last_req;
`ifdef CLAHE_RESIDUAL_EN
    last_req = 8'd255;
`else
    last_req = 8'd243;
`endif
    for (int b = 0; b < 256; b++) mem[b] = 16'd0;
    mem[100] = 16'd4096;
    model();
    pulse_start(1'b0, 4'd7);
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL spike_done_timeout got=0 required=1"); end
    checks++;
    if (cap[1][0] !== 8'd0) begin
      failures++; $display("FAIL spike_map0 got=%0d required=0", cap[1][0]);
    end
    checks++;
    if (cap[1][255] !== last_req) begin
      failures++; $display("FAIL spike_map255 got=%0d required=%0d", cap[1][255], last_req);
    end
    bad = 0;
    for (int k = 0; k < 256; k++) if (cap[1][k] !== exp_map[k]) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL spike_map_model got=%0d required=0", bad);
    end
  endtask

  task automatic test_select();
    bit ok;
    checks++;
    if (rb[1] !== 32'd0) begin
      failures++; $display("FAIL select_idle_rden got=%h required=0", rb[1]);
    end
    pulse_start(1'b1, 4'd3);
    checks++;
    if (pa[1] !== 8'd0) begin
      failures++; $display("FAIL select_first_addr got=%0d required=0", pa[1]);
    end
    checks++;
    if (rb[1] !== 32'h0008_0000) begin
      failures++; $display("FAIL select_rden got=%h required=00080000", rb[1]);
    end
    checks++;
    if (bz[1] !== 1'b1) begin
      failures++; $display("FAIL select_busy got=%b required=1", bz[1]);
    end
    wait_done(ok);
    checks++;
    if (!ok || selerr != 0) begin
      failures++; $display("FAIL select_rden_hold got=%0d required=0 ok=%0d", selerr, ok);
    end
    checks++;
    if (rb[1] !== 32'd0 || pa[1] !== 8'd0) begin
      failures++; $display("FAIL select_idle_after got=%h/%0d required=0/0", rb[1], pa[1]);
    end
  endtask

  task automatic test_latency();
    bit ok;
    int bad;
    for (int b = 0; b < 256; b++)
      mem[b] = (b % 37 == 5) ? 16'd300 : 16'($urandom_range(0, 20));
    model();
    pulse_start(1'b0, 4'd2);
    wait_done(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL latency_done_timeout got=0 required=1"); end
    for (int i = 0; i < 3; i++) begin
      bad = 0;
      for (int k = 0; k < 256; k++) if (cap[i][k] !== exp_map[k]) bad++;
      checks++;
      if (bad != 0 || vcnt[i] != 256) begin
        failures++;
        $display("FAIL latency_map_lat%0d got=%0d/%0d required=0/256", i + 1, bad, vcnt[i]);
      end
    end
    checks++;
    if ((dcyc[1] - scyc) - (dcyc[0] - scyc) != 2) begin
      failures++; $display("FAIL latency_step12 got=%0d required=2", dcyc[1] - dcyc[0]);
    end
    checks++;
    if ((dcyc[2] - scyc) - (dcyc[1] - scyc) != 2) begin
      failures++; $display("FAIL latency_step23 got=%0d required=2", dcyc[2] - dcyc[1]);
    end
  endtask

  task automatic test_second_start();
    bit ok, seen;
    int bad;
    model();
    pulse_start(1'b0, 4'd0);
    seen = 1'b0;
    for (int n = 0; n < 1000 && !seen; n++) begin
      @(negedge clk);
      seen = mv[1];
    end
    tile_sel = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    repeat (600) @(negedge clk);
    checks++;
    if (!ok || dcnt[1] != 1) begin
      failures++; $display("FAIL second_start_done_count got=%0d required=1", dcnt[1]);
    end
    checks++;
    if (vcnt[1] != 256 || selerr != 0 || bz[1] !== 1'b0) begin
      failures++;
      $display("FAIL second_start_stream got=%0d/%0d/%b required=256/0/0", vcnt[1], selerr, bz[1]);
    end
    bad = 0;
    for (int k = 0; k < 256; k++) if (cap[1][k] !== exp_map[k]) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL second_start_map got=%0d required=0", bad);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, hit;
    int bad;
    logic [63:0] o;
    for (int b = 0; b < 256; b++) mem[b] = 16'(b % 40);
    mem[17] = 16'd900;
    model();
    pulse_start(1'b0, 4'd1);
    hit = 1'b0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      @(negedge clk);
      hit = mv[1] && (pa[1] == 8'd130);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL reset_mid_reach got=0 required=1"); end
    rst_n = 1'b0;
    #1;
    o = {pa[1], rb[1], mv[1], ma[1], md[1], bz[1], dn[1]};
    checks++;
    if (o !== 64'd0) begin
      failures++; $display("FAIL reset_mid_outputs got=%h required=0", o);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (dcnt[1] != 0) begin
      failures++; $display("FAIL reset_mid_no_done got=%0d required=0", dcnt[1]);
    end
    pulse_start(1'b0, 4'd1);
    wait_done(ok);
    bad = 0;
    for (int k = 0; k < 256; k++) if (cap[1][k] !== exp_map[k]) bad++;
    checks++;
    if (!ok || bad != 0 || vcnt[1] != 256) begin
      failures++;
      $display("FAIL reset_mid_restart got=%0d/%0d required=0/256", bad, vcnt[1]);
    end
  endtask

  initial begin
    clear_caps();
    for (int b = 0; b < 256; b++) mem[b] = 16'd0;
    test_reset();
    test_uniform();
    test_spike();
    test_select();
    test_latency();
    test_second_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
